port_input_conditioner: RTL and testbench

PORT_INPUT_CONDITIONER -- requirements
Module: port_input_conditioner

---
 rtl/port_input_conditioner.sv | 72 +++++++
 tb/tb_port_input_conditioner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/port_input_conditioner.sv
// Purpose: synchronize, debounce and edge-detect an 8-bit vector of board switch/button levels.
// Latency: a held input change appears on iport STABLE_CYCLES+3 clock edges after it is first sampled.
// Backpressure: none; free-running, raw_in is sampled every clock and all outputs are registered.
module port_input_conditioner #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] raw_in,
    input  logic [7:0] clear_mask,
    output logic [7:0] iport,
    output logic [7:0] edge_flags,
    output logic       changed
);

    // Last count value; the counter parks here once the candidate has been stable long enough.
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] cand;
    logic [7:0] cnt;
    logic       stable;
    logic       accept;
    logic [7:0] rise;

    // The candidate has survived the full window and differs from what is being presented.
    assign stable = (sync2 == cand) && (cnt == CNT_MAX);
    assign accept = stable && (cand != iport);
    // Only bits going 0->1 on an accepting edge raise a flag; falling bits contribute nothing.
    assign rise   = accept ? (cand & ~iport) : 8'h00;

    // Two-flop synchronizer for the asynchronous pin levels.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Whole-vector debounce: any bit change reloads the candidate and restarts the window.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cand <= 8'h00;
            cnt  <= 8'h00;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= 8'h00;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Registered outputs: accepted level, one-cycle change pulse, sticky rise flags (set beats clear).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            iport      <= 8'h00;
            edge_flags <= 8'h00;
            changed    <= 1'b0;
        end else begin
            if (accept) begin
                iport <= cand;
            end
            changed    <= accept;
            edge_flags <= (edge_flags & ~clear_mask) | rise;
        end
    end

endmodule

// File: tb/tb_port_input_conditioner.sv
module tb_port_input_conditioner;

    logic       clock;
    logic       reset_n;
    logic [7:0] raw_in;
    logic [7:0] clear_mask;
    logic [7:0] iport;
    logic [7:0] edge_flags;
    logic       changed;
    logic [7:0] iport1;
    logic [7:0] edge_flags1;
    logic       changed1;

    int n_cmp = 0;
    int n_err = 0;

    port_input_conditioner #(.STABLE_CYCLES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .clear_mask (clear_mask),
        .iport      (iport),
        .edge_flags (edge_flags),
        .changed    (changed)
    );

    port_input_conditioner #(.STABLE_CYCLES(1)) dut1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .clear_mask (clear_mask),
        .iport      (iport1),
        .edge_flags (edge_flags1),
        .changed    (changed1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reset for two edges while raw_in already carries the given value.
    task automatic apply_reset(input logic [7:0] val);
        reset_n    = 1'b0;
        raw_in     = val;
        clear_mask = 8'h00;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        raw_in     = 8'hFF;
        clear_mask = 8'h00;
        tick(3);
        n_cmp++;
        if (iport !== 8'h00) begin n_err++; $display("FAIL reset_iport got %h want 00", iport); end
        n_cmp++;
        if (edge_flags !== 8'h00) begin n_err++; $display("FAIL reset_flags got %h want 00", edge_flags); end
        n_cmp++;
        if (changed !== 1'b0) begin n_err++; $display("FAIL reset_changed got %b want 0", changed); end
        n_cmp++;
        if (dut.sync2 !== 8'h00) begin n_err++; $display("FAIL reset_priority_sync2 got %h want 00", dut.sync2); end
    endtask

    task automatic test_acquire();
        apply_reset(8'hA5);
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            n_cmp++;
            if (iport !== 8'h00 || changed !== 1'b0) begin
                n_err++; $display("FAIL acquire_wait edge %0d iport %h changed %b want 00/0", e, iport, changed);
            end
        end
        tick(1);
        n_cmp++;
        if (iport !== 8'hA5) begin n_err++; $display("FAIL acquire_iport got %h want a5", iport); end
        n_cmp++;
        if (changed !== 1'b1) begin n_err++; $display("FAIL acquire_changed got %b want 1", changed); end
        n_cmp++;
        if (edge_flags !== 8'hA5) begin n_err++; $display("FAIL acquire_flags got %h want a5", edge_flags); end
        tick(1);
        n_cmp++;
        if (changed !== 1'b0) begin n_err++; $display("FAIL acquire_pulse_width got %b want 0", changed); end
        tick(300);
        n_cmp++;
        if (dut.cnt !== 8'd3) begin n_err++; $display("FAIL cnt_saturate got %0d want 3", dut.cnt); end
        n_cmp++;
        if (iport !== 8'hA5 || changed !== 1'b0) begin
            n_err++; $display("FAIL long_hold iport %h changed %b want a5/0", iport, changed);
        end
    endtask

    task automatic test_glitch();
        apply_reset(8'h00);
        tick(10);
        // Three-cycle and four-cycle glitches must both be rejected.
        for (int len = 3; len <= 4; len++) begin
            raw_in = 8'h01;
            for (int c = 0; c < 15; c++) begin
                if (c == len) raw_in = 8'h00;
                tick(1);
                n_cmp++;
                if (iport !== 8'h00 || changed !== 1'b0 || edge_flags !== 8'h00) begin
                    n_err++;
                    $display("FAIL glitch%0d cyc %0d iport %h changed %b flags %h want 00/0/00",
                             len, c, iport, changed, edge_flags);
                end
            end
        end
        // A five-cycle pulse is just long enough to be accepted on the 7th edge.
        raw_in = 8'h01;
        tick(5);
        raw_in = 8'h00;
        tick(1);
        n_cmp++;
        if (iport !== 8'h00) begin n_err++; $display("FAIL pulse5_early got %h want 00", iport); end
        tick(1);
        n_cmp++;
        if (iport !== 8'h01 || changed !== 1'b1) begin
            n_err++; $display("FAIL pulse5_accept iport %h changed %b want 01/1", iport, changed);
        end
        tick(10);
        n_cmp++;
        if (iport !== 8'h00 || edge_flags !== 8'h01) begin
            n_err++; $display("FAIL pulse5_return iport %h flags %h want 00/01", iport, edge_flags);
        end
    endtask

    task automatic test_update_and_clear();
        apply_reset(8'hA5);
        tick(7);
        raw_in = 8'h5A;
        tick(6);
        n_cmp++;
        if (iport !== 8'hA5) begin n_err++; $display("FAIL update_hold got %h want a5", iport); end
        tick(1);
        n_cmp++;
        if (iport !== 8'h5A || edge_flags !== 8'hFF) begin
            n_err++; $display("FAIL update_5a iport %h flags %h want 5a/ff", iport, edge_flags);
        end
        clear_mask = 8'h0F;
        tick(1);
        clear_mask = 8'h00;
        n_cmp++;
        if (edge_flags !== 8'hF0) begin n_err++; $display("FAIL clear_0f got %h want f0", edge_flags); end
        // Falling to zero must leave the flags alone.
        raw_in = 8'h00;
        tick(7);
        n_cmp++;
        if (iport !== 8'h00 || changed !== 1'b1 || edge_flags !== 8'hF0) begin
            n_err++; $display("FAIL fall_only iport %h changed %b flags %h want 00/1/f0", iport, changed, edge_flags);
        end
    endtask

    task automatic test_set_wins();
        apply_reset(8'h00);
        tick(10);
        raw_in = 8'h01;
        tick(6);
        clear_mask = 8'h01;
        tick(1);
        n_cmp++;
        if (iport !== 8'h01 || edge_flags !== 8'h01) begin
            n_err++; $display("FAIL set_wins iport %h flags %h want 01/01", iport, edge_flags);
        end
        tick(1);
        clear_mask = 8'h00;
        n_cmp++;
        if (edge_flags !== 8'h00) begin n_err++; $display("FAIL clear_after got %h want 00", edge_flags); end
    endtask

    task automatic test_toggle();
        apply_reset(8'h00);
        tick(10);
        for (int i = 0; i < 24; i++) begin
            raw_in = (i % 2 == 0) ? 8'h08 : 8'h00;
            tick(2);
            n_cmp++;
            if (iport !== 8'h00 || changed !== 1'b0) begin
                n_err++; $display("FAIL toggle step %0d iport %h changed %b want 00/0", i, iport, changed);
            end
        end
        raw_in = 8'h08;
        tick(6);
        n_cmp++;
        if (iport !== 8'h00) begin n_err++; $display("FAIL toggle_hold6 got %h want 00", iport); end
        tick(1);
        n_cmp++;
        if (iport !== 8'h08) begin n_err++; $display("FAIL toggle_hold7 got %h want 08", iport); end
    endtask

    task automatic test_reset_midcount();
        apply_reset(8'hA5);
        tick(7);
        raw_in = 8'h3C;
        tick(5);
        n_cmp++;
        if (dut.cnt !== 8'd2 || iport !== 8'hA5) begin
            n_err++; $display("FAIL midcount_pre cnt %0d iport %h want 2/a5", dut.cnt, iport);
        end
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        n_cmp++;
        if (iport !== 8'h00 || edge_flags !== 8'h00 || changed !== 1'b0) begin
            n_err++; $display("FAIL midcount_reset iport %h flags %h changed %b want 00/00/0", iport, edge_flags, changed);
        end
        tick(6);
        n_cmp++;
        if (iport !== 8'h00) begin n_err++; $display("FAIL midcount_wait got %h want 00", iport); end
        tick(1);
        n_cmp++;
        if (iport !== 8'h3C || changed !== 1'b1) begin
            n_err++; $display("FAIL midcount_reacq iport %h changed %b want 3c/1", iport, changed);
        end
    endtask

    task automatic test_stable1();
        apply_reset(8'hC3);
        tick(3);
        n_cmp++;
        if (iport1 !== 8'h00) begin n_err++; $display("FAIL s1_wait got %h want 00", iport1); end
        tick(1);
        n_cmp++;
        if (iport1 !== 8'hC3 || changed1 !== 1'b1 || edge_flags1 !== 8'hC3) begin
            n_err++; $display("FAIL s1_accept iport %h changed %b flags %h want c3/1/c3", iport1, changed1, edge_flags1);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        raw_in     = 8'h00;
        clear_mask = 8'h00;
        test_reset();
        test_acquire();
        test_glitch();
        test_update_and_clear();
        test_set_wins();
        test_toggle();
        test_reset_midcount();
        test_stable1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
